// File: rtl/nco_pkg.sv
// Shared NCO constants and wave loader types, so the loader and the NCO agree on RAM geometry.
package nco_pkg;

  localparam int          NCO_ADDR_WIDTH = 12;
  localparam int          NCO_DEPTH      = 4096;
  localparam logic [7:0]  NCO_SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4
  } wave_load_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/wave_loader_if.sv
// Byte stream in, waveform RAM write port and frame status out.
// master: the loader side. slave: the UART / NCO / register-file side.
interface wave_loader_if import nco_pkg::*; #(
  parameter int ADDR_WIDTH = NCO_ADDR_WIDTH
);
  logic [7:0]            rx_data_i;
  logic                  rx_valid_i;
  logic [7:0]            wave_data_o;
  logic [ADDR_WIDTH-1:0] wave_addr_o;
  logic                  wave_load_en_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [1:0]            err_code_o;
  logic                  table_valid_o;

  modport master (
    input  rx_data_i, rx_valid_i,
    output wave_data_o, wave_addr_o, wave_load_en_o,
    output busy_o, done_o, err_o, err_code_o, table_valid_o
  );

  modport slave (
    output rx_data_i, rx_valid_i,
    input  wave_data_o, wave_addr_o, wave_load_en_o,
    input  busy_o, done_o, err_o, err_code_o, table_valid_o
  );
endinterface

// File: rtl/wave_loader.sv
// Parses SYNC/LEN_HI/LEN_LO/data/CHK frames and writes the data into the NCO waveform RAM.
module wave_loader import nco_pkg::*; #(
  parameter int         ADDR_WIDTH     = NCO_ADDR_WIDTH,
  parameter int         DEPTH          = NCO_DEPTH,
  parameter logic [7:0] SYNC_BYTE      = NCO_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 5_000_000
) (
  input logic             clk,
  input logic             rst_n,
  wave_loader_if.master   bus
);

  localparam int          GAP_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  // gap_q counts idle edges since the last byte; the edge that would bring it to
  // TIMEOUT_CYCLES-1 is the expiry edge.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 2);

  wave_load_state_t      state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            xor_q, xor_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  valid_q, valid_d;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] len_w;
  logic        expire;

  assign rx_data  = bus.rx_data_i;
  assign rx_valid = bus.rx_valid_i;
  assign len_w    = {len_hi_q, rx_data};
  // A byte in the expiry cycle wins, so expiry is qualified with !rx_valid.
  assign expire   = (state_q != S_IDLE) && !rx_valid && (gap_q == GAP_LAST);

  // Frame parser: next state, counters, RAM write and status pulses.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    xor_d    = xor_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    valid_d  = valid_q;
    gap_d    = (state_q == S_IDLE || rx_valid) ? '0 : gap_q + GAP_W'(1);

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN_HI;
            code_d  = ERR_NONE;
            xor_d   = 8'h00;
          end
        end
        S_LEN_HI: begin
          len_hi_d = rx_data;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (len_w == 16'd0 || 17'(len_w) > DEPTH_L) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_IDLE;
          end else begin
            valid_d = 1'b0;
            addr_d  = '0;
            rem_d   = len_w;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          wdata_d = rx_data;
          waddr_d = addr_q;
          we_d    = 1'b1;
          xor_d   = xor_q ^ rx_data;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_CHK;
        end
        S_CHK: begin
          if (rx_data == xor_q) begin
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = S_IDLE;
    end
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      xor_q    <= '0;
      gap_q    <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      xor_q    <= xor_d;
      gap_q    <= gap_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.wave_data_o    = wdata_q;
  assign bus.wave_addr_o    = waddr_q;
  assign bus.wave_load_en_o = we_q;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.done_o         = done_q;
  assign bus.err_o          = err_q;
  assign bus.err_code_o     = code_q;
  assign bus.table_valid_o  = valid_q;

endmodule
